// File: rtl/nes_pad_emulator.sv
// rtl/nes_pad_emulator.sv - UDP button packets to a NES controller-port shift register
module nes_pad_emulator #(
    parameter int WORD_INDEX     = 0,
    parameter int TIMEOUT_CYCLES = 25_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        axiiv,
    input  logic [15:0] axiid,
    input  logic        latch_in,
    input  logic        pulse_in,
    output logic        data_out,
    output logic [7:0]  buttons_held,
    output logic        link_alive,
    output logic [7:0]  good_count,
    output logic [7:0]  bad_count
);
    localparam int            TW           = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_MAX  = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]    WORD_SEL     = 8'(WORD_INDEX);

    typedef enum logic {
        S_LOAD,
        S_SHIFT
    } state_t;

    logic [7:0]    word_idx;
    logic [TW-1:0] idle_cnt;
    logic          at_word;
    logic          byte_match;
    logic          short_burst;
    logic          good_pkt;
    logic          bad_pkt;

    logic [2:0]    latch_sync;
    logic [2:0]    pulse_sync;
    logic          latch_lvl;
    logic          latch_prev;
    logic          pulse_rise;

    state_t        state;
    state_t        state_n;
    logic [7:0]    sr;
    logic [7:0]    sr_n;
    logic [3:0]    shift_cnt;
    logic [3:0]    shift_cnt_n;
    logic          data_n;

    // A burst that drops before the selected word leaves word_idx in 1..WORD_SEL
    assign at_word     = axiiv && (word_idx == WORD_SEL);
    assign byte_match  = (axiid[15:8] == axiid[7:0]);
    assign short_burst = !axiiv && (word_idx != 8'd0) && (word_idx <= WORD_SEL);
    assign good_pkt    = at_word && byte_match;
    assign bad_pkt     = (at_word && !byte_match) || short_burst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_idx <= 8'd0;
        end else if (!axiiv) begin
            word_idx <= 8'd0;
        end else if (word_idx != 8'hFF) begin
            word_idx <= word_idx + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buttons_held <= 8'd0;
            link_alive   <= 1'b0;
            idle_cnt     <= '0;
            good_count   <= 8'd0;
            bad_count    <= 8'd0;
        end else begin
            if (bad_pkt) begin
                bad_count <= bad_count + 8'd1;
            end
            if (good_pkt) begin
                buttons_held <= axiid[7:0];
                link_alive   <= 1'b1;
                idle_cnt     <= '0;
                good_count   <= good_count + 8'd1;
            end else if (idle_cnt != TIMEOUT_MAX) begin
                idle_cnt <= idle_cnt + 1'b1;
                if (idle_cnt == TIMEOUT_LAST) begin
                    buttons_held <= 8'd0;
                    link_alive   <= 1'b0;
                end
            end
        end
    end

    // [1] is the synchronized level, [2] the previous level for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            latch_sync <= 3'b000;
            pulse_sync <= 3'b000;
        end else begin
            latch_sync <= {latch_sync[1:0], latch_in};
            pulse_sync <= {pulse_sync[1:0], pulse_in};
        end
    end

    assign latch_lvl  = latch_sync[1];
    assign latch_prev = latch_sync[2];
    assign pulse_rise = pulse_sync[1] && !pulse_sync[2];

    always_comb begin
        state_n     = state;
        sr_n        = sr;
        shift_cnt_n = shift_cnt;
        case (state)
            S_LOAD:  if (!latch_lvl && latch_prev) state_n = S_SHIFT;
            S_SHIFT: if (latch_lvl && !latch_prev) state_n = S_LOAD;
            default: state_n = S_SHIFT;
        endcase
        // Load has priority over pulses and tracks buttons_held every cycle
        if (state_n == S_LOAD) begin
            sr_n        = buttons_held;
            shift_cnt_n = 4'd0;
        end else if (pulse_rise && (shift_cnt != 4'd8)) begin
            sr_n        = {1'b0, sr[7:1]};
            shift_cnt_n = shift_cnt + 4'd1;
        end
        data_n = (shift_cnt_n == 4'd8) ? 1'b0 : ~sr_n[0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_SHIFT;
            sr        <= 8'd0;
            shift_cnt <= 4'd8;
            data_out  <= 1'b0;
        end else begin
            state     <= state_n;
            sr        <= sr_n;
            shift_cnt <= shift_cnt_n;
            data_out  <= data_n;
        end
    end

endmodule

// File: tb/tb_nes_pad_emulator.sv
// tb/tb_nes_pad_emulator.sv - scoreboard bench for nes_pad_emulator
module tb_nes_pad_emulator;

    typedef struct {
        int         d;
        logic [7:0] btn;
        logic       link;
        logic [7:0] good;
        logic [7:0] bad;
        logic       dout;
        int         cyc;
    } pkt_exp_t;

    localparam logic [0:9] E_05 = 10'b0101111100;
    localparam logic [0:9] E_A5 = 10'b0101101000;
    localparam logic [0:9] E_01 = 10'b0111111100;
    localparam logic [0:9] E_5A = 10'b1010010100;

    logic        clk;
    logic        rst;
    logic        axiiv [2];
    logic [15:0] axiid [2];
    logic        latch_in;
    logic        pulse_in;
    logic        dout  [2];
    logic [7:0]  btn   [2];
    logic        link  [2];
    logic [7:0]  good  [2];
    logic [7:0]  bad   [2];

    int          n_chk  = 0;
    int          n_fail = 0;
    int          cyc    = 0;
    bit          mon_en = 0;

    pkt_exp_t    pkt_q [$];
    pkt_exp_t    rst_q [$];
    int          to_q  [$];
    logic        bit_q [$];

    logic [7:0]  m_btn  [2];
    logic        m_link [2];
    logic [7:0]  m_good [2];
    logic [7:0]  m_bad  [2];

    nes_pad_emulator #(.WORD_INDEX(0), .TIMEOUT_CYCLES(1_000_000)) dut_a (
        .clk(clk), .rst(rst), .axiiv(axiiv[0]), .axiid(axiid[0]),
        .latch_in(latch_in), .pulse_in(pulse_in), .data_out(dout[0]),
        .buttons_held(btn[0]), .link_alive(link[0]),
        .good_count(good[0]), .bad_count(bad[0])
    );

    nes_pad_emulator #(.WORD_INDEX(2), .TIMEOUT_CYCLES(100)) dut_b (
        .clk(clk), .rst(rst), .axiiv(axiiv[1]), .axiid(axiid[1]),
        .latch_in(latch_in), .pulse_in(pulse_in), .data_out(dout[1]),
        .buttons_held(btn[1]), .link_alive(link[1]),
        .good_count(good[1]), .bad_count(bad[1])
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_burst(input int d, input logic [63:0] words, input int n, input int off);
        pkt_exp_t e;
        @(posedge clk);
        #1;
        e.d = d; e.btn = m_btn[d]; e.link = m_link[d];
        e.good = m_good[d]; e.bad = m_bad[d]; e.dout = 1'b0; e.cyc = cyc + off;
        pkt_q.push_back(e);
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            axiiv[d] = 1'b1;
            axiid[d] = words[16*i +: 16];
        end
        @(posedge clk);
        #1;
        axiiv[d] = 1'b0;
        axiid[d] = 16'h0000;
        repeat (2) @(posedge clk);
    endtask

    task automatic latch_for(input int n, input logic e);
        bit_q.push_back(e);
        @(posedge clk);
        #1 latch_in = 1'b1;
        repeat (n) @(posedge clk);
        #1 latch_in = 1'b0;
    endtask

    task automatic pulse_for(input int half, input logic e);
        bit_q.push_back(e);
        @(posedge clk);
        #1 pulse_in = 1'b1;
        repeat (half) @(posedge clk);
        #1 pulse_in = 1'b0;
        repeat (half) @(posedge clk);
    endtask

    task automatic read_bits(input logic [0:9] e, input int from, input int to, input int half);
        for (int k = from; k <= to; k++) pulse_for(half, e[k]);
    endtask

    task automatic clear_model();
        for (int d = 0; d < 2; d++) begin
            m_btn[d] = 8'h00; m_link[d] = 1'b0; m_good[d] = 8'h00; m_bad[d] = 8'h00;
        end
    endtask

    initial begin : count_mon
        logic [7:0] pg [2];
        logic [7:0] pb [2];
        logic       pl [2];
        int         lastgood [2];
        pkt_exp_t   e;
        int         t;
        lastgood[0] = 0;
        lastgood[1] = 0;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (!rst) begin
                    if (pl[d] && !link[d]) begin
                        chk($sformatf("dut%0d timeout expected", d), int'(to_q.size() != 0), 1);
                        if (to_q.size() != 0) begin
                            t = to_q.pop_front();
                            chk($sformatf("dut%0d timeout latency", d), cyc - lastgood[d], t);
                            chk($sformatf("dut%0d buttons after timeout", d), int'(btn[d]), 0);
                        end
                    end
                    if (good[d] != pg[d] || bad[d] != pb[d]) begin
                        chk($sformatf("dut%0d packet expected", d), int'(pkt_q.size() != 0), 1);
                        if (pkt_q.size() != 0) begin
                            e = pkt_q.pop_front();
                            chk("packet dut", d, e.d);
                            chk($sformatf("dut%0d buttons_held", d), int'(btn[d]), int'(e.btn));
                            chk($sformatf("dut%0d link_alive", d), int'(link[d]), int'(e.link));
                            chk($sformatf("dut%0d good_count", d), int'(good[d]), int'(e.good));
                            chk($sformatf("dut%0d bad_count", d), int'(bad[d]), int'(e.bad));
                            chk($sformatf("dut%0d packet cycle", d), cyc, e.cyc);
                        end
                        if (good[d] != pg[d]) lastgood[d] = cyc;
                    end
                end
                pg[d] = good[d];
                pb[d] = bad[d];
                pl[d] = link[d];
            end
        end
    end

    initial begin : rst_mon
        pkt_exp_t e;
        forever begin
            @(posedge rst);
            #1;
            chk("reset expected", int'(rst_q.size() != 0), 1);
            if (rst_q.size() != 0) begin
                e = rst_q.pop_front();
                for (int d = 0; d < 2; d++) begin
                    chk($sformatf("dut%0d reset buttons_held", d), int'(btn[d]), int'(e.btn));
                    chk($sformatf("dut%0d reset link_alive", d), int'(link[d]), int'(e.link));
                    chk($sformatf("dut%0d reset good_count", d), int'(good[d]), int'(e.good));
                    chk($sformatf("dut%0d reset bad_count", d), int'(bad[d]), int'(e.bad));
                    chk($sformatf("dut%0d reset data_out", d), int'(dout[d]), int'(e.dout));
                end
            end
        end
    end

    initial begin : bit_mon
        logic e;
        forever begin
            @(negedge latch_in or negedge pulse_in);
            if (mon_en) begin
                chk("data_out sample expected", int'(bit_q.size() != 0), 1);
                if (bit_q.size() != 0) begin
                    e = bit_q.pop_front();
                    chk($sformatf("data_out sample %0d", n_chk), int'(dout[0]), int'(e));
                end
            end
        end
    end

    initial begin : watchdog
        repeat (60000) @(posedge clk);
        n_fail++;
        $display("FAIL watchdog: actual running required finished");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        pkt_exp_t z;
        z.d = 0; z.btn = 8'h00; z.link = 1'b0; z.good = 8'h00; z.bad = 8'h00;
        z.dout = 1'b0; z.cyc = 0;
        rst = 1'b0;
        latch_in = 1'b0;
        pulse_in = 1'b0;
        for (int d = 0; d < 2; d++) begin
            axiiv[d] = 1'b0;
            axiid[d] = 16'h0000;
        end
        clear_model();
        rst_q.push_back(z);
        #3 rst = 1'b1;
        repeat (3) @(posedge clk);
        #5 rst = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(posedge clk);

        // good, bad, and a 2-word burst whose second word is not inspected
        m_btn[0] = 8'h81; m_link[0] = 1'b1; m_good[0]++;
        send_burst(0, 64'h0000_0000_0000_8181, 1, 1);
        m_bad[0]++;
        send_burst(0, 64'h0000_0000_0000_8180, 1, 1);
        m_btn[0] = 8'h42; m_good[0]++;
        send_burst(0, 64'h0000_0000_1234_4242, 2, 1);

        // WORD_INDEX=2 instance: short burst, then timeout and recovery twice
        m_bad[1]++;
        send_burst(1, 64'h0000_0000_2222_1111, 2, 3);
        m_btn[1] = 8'hFF; m_link[1] = 1'b1; m_good[1]++;
        to_q.push_back(100);
        send_burst(1, 64'h0000_FFFF_1234_0000, 3, 3);
        repeat (130) @(posedge clk);
        m_good[1]++;
        to_q.push_back(100);
        send_burst(1, 64'h0000_FFFF_0000_0000, 3, 3);
        repeat (130) @(posedge clk);

        // full-speed console read of 8'h05 plus a 9th pulse
        m_btn[0] = 8'h05; m_good[0]++;
        send_burst(0, 64'h0000_0000_0000_0505, 1, 1);
        latch_for(600, E_05[0]);
        read_bits(E_05, 1, 9, 300);

        // packet arriving mid-shift must not disturb the bits in flight
        m_btn[0] = 8'hA5; m_good[0]++;
        send_burst(0, 64'h0000_0000_0000_A5A5, 1, 1);
        latch_for(12, 1'b0);
        read_bits(E_A5, 1, 3, 6);
        m_btn[0] = 8'h01; m_good[0]++;
        send_burst(0, 64'h0000_0000_0000_0101, 1, 1);
        read_bits(E_A5, 4, 8, 6);
        latch_for(12, 1'b0);
        read_bits(E_01, 1, 8, 6);

        // re-latch mid-read restarts at A
        m_btn[0] = 8'h5A; m_good[0]++;
        send_burst(0, 64'h0000_0000_0000_5A5A, 1, 1);
        latch_for(12, 1'b1);
        read_bits(E_5A, 1, 2, 6);
        latch_for(12, 1'b1);
        read_bits(E_5A, 1, 8, 6);

        // asynchronous reset while pulse 2 is high
        latch_for(12, 1'b1);
        read_bits(E_5A, 1, 1, 6);
        bit_q.push_back(1'b0);
        @(posedge clk);
        #1 pulse_in = 1'b1;
        repeat (4) @(posedge clk);
        #5;
        rst_q.push_back(z);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #5 rst = 1'b0;
        clear_model();
        repeat (3) @(posedge clk);
        #1 pulse_in = 1'b0;
        repeat (6) @(posedge clk);
        pulse_for(6, 1'b0);
        pulse_for(6, 1'b0);
        latch_for(12, 1'b1);
        pulse_for(6, 1'b1);

        repeat (10) @(posedge clk);
        chk("packet queue drained", pkt_q.size(), 0);
        chk("timeout queue drained", to_q.size(), 0);
        chk("bit queue drained", bit_q.size(), 0);
        chk("reset queue drained", rst_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
